// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared FSM encoding and PS/2 frame constants
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic       PS2_START_BIT    = 1'b0;
  localparam logic       PS2_STOP_BIT     = 1'b1;
  localparam int         PS2_DATA_BITS    = 8;
  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

endpackage

// File: rtl/ps2_input_filter.sv
// rtl/ps2_input_filter.sv - pin synchronisers, PS2_clk glitch filter and falling-edge bit strobe
module ps2_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic bit_strobe,
  output logic data_sync
);

  localparam int FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]     clk_s;
  logic [1:0]     data_s;
  logic           filt;
  logic [FCW-1:0] fcnt;
  logic           flip;

  // filt only follows the synchronised clock after FILTER_LEN consecutive disagreeing samples
  assign flip      = (clk_s[1] != filt) && (fcnt == FCW'(FILTER_LEN - 1));
  assign data_sync = data_s[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s      <= 2'b11;
      data_s     <= 2'b11;
      filt       <= 1'b1;
      fcnt       <= '0;
      bit_strobe <= 1'b0;
    end else begin
      clk_s      <= {clk_s[0], ps2_clk};
      data_s     <= {data_s[0], ps2_data};
      bit_strobe <= flip && filt;
      if (clk_s[1] == filt) begin
        fcnt <= '0;
      end else if (flip) begin
        filt <= clk_s[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 frame receiver; PS2_RX_PREFIX_MERGE_EN folds E0/F0 prefixes into flags
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       extended_flag,
  output logic       break_flag,
  output logic       frame_error,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  ps2_state_t    state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_cnt, cnt_n;
  logic          parity_ok, par_n;
  logic [TW-1:0] timeout_cnt;
  logic          bit_strobe, data_sync;
  logic          timeout_hit, frame_ok, frame_bad;
`ifdef PS2_RX_PREFIX_MERGE_EN
  logic          pend_ext, pend_brk;
`endif

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk        (system_clk),
    .rst_n      (reset),
    .ps2_clk    (PS2_clk),
    .ps2_data   (PS2_data),
    .bit_strobe (bit_strobe),
    .data_sync  (data_sync)
  );

  assign busy = (state != ST_IDLE);

  // fires as the counter would reach TIMEOUT_CYCLES-1, so the error pulse coincides with that count
  assign timeout_hit = busy && !bit_strobe && (timeout_cnt == TW'(TIMEOUT_CYCLES - 2));

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    cnt_n     = bit_cnt;
    par_n     = parity_ok;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (bit_strobe) begin
      case (state)
        ST_IDLE: begin
          if (data_sync == PS2_START_BIT) begin
            state_n = ST_DATA;
            cnt_n   = '0;
          end
        end
        ST_DATA: begin
          shift_n = {data_sync, shift[7:1]};
          cnt_n   = bit_cnt + 1'b1;
          if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_n = ST_PARITY;
        end
        ST_PARITY: begin
          par_n   = ^{shift, data_sync};
          state_n = ST_STOP;
        end
        default: begin
          if (data_sync == PS2_STOP_BIT && parity_ok) frame_ok = 1'b1;
          else                                        frame_bad = 1'b1;
          state_n = ST_IDLE;
        end
      endcase
    end else if (timeout_hit) begin
      state_n   = ST_IDLE;
      frame_bad = 1'b1;
    end
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      shift          <= '0;
      bit_cnt        <= '0;
      parity_ok      <= 1'b0;
      timeout_cnt    <= '0;
      scancode       <= 8'h00;
      scancode_valid <= 1'b0;
      extended_flag  <= 1'b0;
      break_flag     <= 1'b0;
      frame_error    <= 1'b0;
`ifdef PS2_RX_PREFIX_MERGE_EN
      pend_ext       <= 1'b0;
      pend_brk       <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      shift          <= shift_n;
      bit_cnt        <= cnt_n;
      parity_ok      <= par_n;
      timeout_cnt    <= (!busy || bit_strobe || timeout_hit) ? '0 : timeout_cnt + 1'b1;
      frame_error    <= frame_bad;
      scancode_valid <= 1'b0;
      extended_flag  <= 1'b0;
      break_flag     <= 1'b0;
`ifdef PS2_RX_PREFIX_MERGE_EN
      if (frame_bad) begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end else if (frame_ok) begin
        if (shift == PS2_PREFIX_EXT) begin
          pend_ext <= 1'b1;
        end else if (shift == PS2_PREFIX_BREAK) begin
          pend_brk <= 1'b1;
        end else begin
          scancode       <= shift;
          scancode_valid <= 1'b1;
          extended_flag  <= pend_ext;
          break_flag     <= pend_brk;
          pend_ext       <= 1'b0;
          pend_brk       <= 1'b0;
        end
      end
`else
      if (frame_ok) begin
        scancode       <= shift;
        scancode_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - directed table-driven bench for ps2_rx_frame
module tb_ps2_rx_frame;

  localparam int FL = 4;
  localparam int TO = 300;
  localparam int HP = 20;

  logic       system_clk = 1'b0;
  logic       reset      = 1'b0;
  logic       PS2_clk    = 1'b1;
  logic       PS2_data   = 1'b1;
  logic [7:0] scancode;
  logic       scancode_valid, extended_flag, break_flag, frame_error, busy;

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .system_clk     (system_clk),
    .reset          (reset),
    .PS2_clk        (PS2_clk),
    .PS2_data       (PS2_data),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .extended_flag  (extended_flag),
    .break_flag     (break_flag),
    .frame_error    (frame_error),
    .busy           (busy)
  );

  always #5 system_clk = ~system_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;
  int nboth = 0;
  int err_cyc = 0;
  int last_fall = 0;
  logic [9:0] vlog [$];

  always @(posedge system_clk) cyc <= cyc + 1;

  always @(negedge system_clk) begin
    if (scancode_valid) begin
      nvalid++;
      vlog.push_back({scancode, extended_flag, break_flag});
    end
    if (frame_error) begin
      nerr++;
      err_cyc = cyc;
    end
    if (scancode_valid && frame_error) nboth++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge system_clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    PS2_data = b;
    wait_cyc(HP);
    PS2_clk   = 1'b0;
    last_fall = cyc;
    wait_cyc(HP);
    PS2_clk = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    logic par;
    par = (~^d) ^ bad_par;
    return {stop, par, d, 1'b0};
  endfunction

  task automatic send_raw(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
    PS2_data = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_code;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int nv0, ne0, waited;
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h1C};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 0, 1, 8'h1C};
    vecs[3] = '{8'h5A, 1'b0, 1'b1, 1, 0, 8'h5A};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1, 0, 8'hFF};
    vecs[6] = '{8'h81, 1'b0, 1'b1, 1, 0, 8'h81};

    wait_cyc(3);
    check("reset_scancode", scancode, 8'h00);
    check("reset_valid", scancode_valid, 0);
    check("reset_error", frame_error, 0);
    check("reset_busy", busy, 0);
    reset = 1'b1;
    wait_cyc(5);

    for (int v = 0; v < 7; v++) begin
      nv0 = nvalid;
      ne0 = nerr;
      send_raw(mk_frame(vecs[v].data, vecs[v].bad_par, vecs[v].stop), 11);
      wait_cyc(HP);
      check($sformatf("vec%0d_valid_cnt", v), nvalid - nv0, vecs[v].exp_valid);
      check($sformatf("vec%0d_err_cnt", v), nerr - ne0, vecs[v].exp_err);
      check($sformatf("vec%0d_scancode", v), scancode, vecs[v].exp_code);
      check($sformatf("vec%0d_busy", v), busy, 0);
    end

    // partial frame abandoned by the timeout
    ne0 = nerr;
    nv0 = nvalid;
    send_raw(mk_frame(8'h1C, 1'b0, 1'b1), 4);
    check("timeout_busy_mid", busy, 1);
    waited = 0;
    while (nerr == ne0 && waited < TO + 100) begin
      wait_cyc(1);
      waited++;
    end
    check("timeout_err_seen", nerr - ne0, 1);
    check("timeout_window", int'((err_cyc - last_fall) >= TO - 1 && (err_cyc - last_fall) <= TO + FL + 8), 1);
    wait_cyc(2);
    check("timeout_busy_after", busy, 0);
    check("timeout_no_valid", nvalid - nv0, 0);
    send_raw(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    wait_cyc(HP);
    check("after_timeout_valid", nvalid - nv0, 1);
    check("after_timeout_code", scancode, 8'h1C);

    // short clock glitches while idle must be ignored
    nv0 = nvalid;
    ne0 = nerr;
    for (int g = 0; g < 5; g++) begin
      PS2_data = 1'b0;
      PS2_clk  = 1'b0;
      wait_cyc(FL - 1);
      PS2_clk = 1'b1;
      wait_cyc(8);
      check($sformatf("glitch%0d_busy", g), busy, 0);
    end
    PS2_data = 1'b1;
    check("glitch_no_err", nerr - ne0, 0);
    check("glitch_no_valid", nvalid - nv0, 0);

    // reset mid-frame
    send_raw(mk_frame(8'h33, 1'b0, 1'b1), 5);
    check("midreset_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_scancode", scancode, 8'h00);
    check("midreset_valid", scancode_valid, 0);
    check("midreset_error", frame_error, 0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(5);
    nv0 = nvalid;
    ne0 = nerr;
    send_raw(mk_frame(8'h33, 1'b0, 1'b1), 11);
    wait_cyc(HP);
    check("postreset_valid", nvalid - nv0, 1);
    check("postreset_err", nerr - ne0, 0);
    check("postreset_code", scancode, 8'h33);

    // E0 F0 75 prefix sequence
    nv0 = nvalid;
    vlog.delete();
    send_raw(mk_frame(8'hE0, 1'b0, 1'b1), 11);
    send_raw(mk_frame(8'hF0, 1'b0, 1'b1), 11);
    send_raw(mk_frame(8'h75, 1'b0, 1'b1), 11);
    wait_cyc(HP);
`ifdef PS2_RX_PREFIX_MERGE_EN
    check("prefix_pulses", nvalid - nv0, 1);
    if (vlog.size() == 1) check("prefix_entry", vlog[0], {8'h75, 1'b1, 1'b1});
    check("prefix_code", scancode, 8'h75);
`else
    check("prefix_pulses", nvalid - nv0, 3);
    if (vlog.size() == 3) begin
      check("prefix_entry0", vlog[0], {8'hE0, 1'b0, 1'b0});
      check("prefix_entry1", vlog[1], {8'hF0, 1'b0, 1'b0});
      check("prefix_entry2", vlog[2], {8'h75, 1'b0, 1'b0});
    end
    check("prefix_code", scancode, 8'h75);
`endif

    check("valid_error_exclusive", nboth, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
PS/2 receive front-end that sits directly upstream of the keyboard character buffer. It synchronises the raw PS2_clk/PS2_data pins into the system_clk domain and filters clock glitches. It deserialises 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) and hands each validated scancode downstream as a one-cycle strobe. Malformed or stalled frames are discarded and reported; they never reach the buffer.

Parameters:
FILTER_LEN, 4, consecutive equal synchronised PS2_clk samples required before the filtered clock changes level (min 2)
TIMEOUT_CYCLES, 50000, system_clk cycles without a bit strobe before a partial frame is abandoned (1 ms at 50 MHz); counter width = clog2(TIMEOUT_CYCLES)

Ports:
system_clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-low reset
PS2_clk  input  1  raw PS/2 clock pin, asynchronous
PS2_data  input  1  raw PS/2 data pin, asynchronous
scancode  output  8  last accepted data byte; held until next accept
scancode_valid  output  1  one-cycle pulse, scancode is new this cycle
extended_flag  output  1  qualifies scancode_valid (E0 prefix seen), see Optional Feature
break_flag  output  1  qualifies scancode_valid (F0 prefix seen), see Optional Feature
frame_error  output  1  one-cycle pulse on parity, stop-bit or timeout failure
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (reset=0, async): sync flops = 1, filtered clk = 1, state IDLE, shift reg/bit_cnt/timeout counter = 0; scancode = 8'h00, scancode_valid/frame_error/extended_flag/break_flag/busy = 0. Reset mid-frame discards the partial frame silently.
- Input path: 2-flop synchroniser per pin. Filtered clk takes the synchronised value only after FILTER_LEN consecutive identical samples. Bit strobe = filtered clk 1->0 transition. Data is taken from the synchronised PS2_data in the strobe cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on strobe with data=0 -> DATA, bit_cnt=0. On strobe with data=1: stay IDLE, no error (line noise).
- DATA: each strobe shifts the bit into bit7 (shift right, LSB first), bit_cnt+1. After the 8th bit -> PARITY.
- PARITY: on strobe, parity_ok = ^{byte, bit}==1 (odd) -> STOP.
- STOP: on strobe, if data=1 and parity_ok, accept; otherwise error. Either way -> IDLE.
- Accept: scancode updated and scancode_valid=1 in the cycle after the stop-bit strobe. Latency from stop strobe = 1 cycle; from pin edge = 2 (sync) + FILTER_LEN + 1.
- Error: frame_error=1 for one cycle, same timing as accept. scancode is unchanged.
- Timeout: counter clears on every strobe and while in IDLE; increments otherwise. On reaching TIMEOUT_CYCLES-1: frame_error pulse, -> IDLE. If a strobe and a terminal count occur in the same cycle, the strobe wins.
- scancode_valid and frame_error are never high in the same cycle.
- busy is combinational from state.

Optional Feature:
Macro PS2_RX_PREFIX_MERGE_EN.
- Defined: an accepted 8'hE0 sets pending_ext and an accepted 8'hF0 sets pending_brk; neither produces scancode_valid. The next accepted non-prefix byte pulses scancode_valid with extended_flag=pending_ext and break_flag=pending_brk, then both pending bits clear. frame_error, timeout and reset also clear the pending bits. Flags are 0 whenever scancode_valid is 0.
- Undefined: every accepted byte, prefixes included, pulses scancode_valid; extended_flag and break_flag are tied 0.

Decomposition:
- Package ps2_pkg: FSM state encoding, PS2_START_BIT=1'b0, PS2_STOP_BIT=1'b1, PS2_DATA_BITS=8, PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BREAK=8'hF0.
- Sub-module ps2_input_filter: synchronisers, FILTER_LEN glitch filter and falling-edge strobe; outputs bit_strobe and data_sync. The top level holds the FSM, the timeout counter and the output registers.

Test Plan:
1. Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12 kHz -> one scancode_valid pulse with scancode=8'h1C; frame_error stays 0; busy returns to 0.
2. Frame 0x1C with parity 1 -> frame_error pulses once, no scancode_valid, scancode keeps its previous value 8'h1C.
3. Frame 0x5A (parity 1) with stop bit 0 -> frame_error pulse. A following good 0x5A frame -> scancode=8'h5A valid.
4. Start bit plus 3 data bits, then idle -> frame_error exactly TIMEOUT_CYCLES-1 cycles after the last strobe, busy=0. A subsequent 0x1C frame is received correctly.
5. PS2_clk low glitches of FILTER_LEN-1 cycles while IDLE -> no state change, busy=0. Then reset asserted mid-frame after 4 data bits -> all outputs 0 immediately, and the next full frame is decoded correctly.
6. Sequence E0, F0, 0x75 -> with PS2_RX_PREFIX_MERGE_EN: one pulse, scancode=8'h75, extended_flag=1, break_flag=1. Without the macro: three pulses E0, F0, 75 with flags 0.
